// File: rtl/debug_rom_walker.sv
// Debug ROM-table walker: checks the component-ID words, then records the base
// address of every present component into a small table for fast readout.
module debug_rom_walker #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE    = '0,
  parameter logic [ADDR_WIDTH-1:0] CID_OFFSET  = 'h1000,
  parameter logic [31:0]           EXP_CID     = 32'h0500_100D,
  parameter int unsigned           MAX_COMP    = 8,
  parameter int unsigned           MAX_ENTRIES = 960
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  output logic [ADDR_WIDTH-1:0]         rom_addr_o,
  input  logic [DATA_WIDTH-1:0]         rom_rdata_i,
  input  logic                          rom_ready_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [1:0]                    err_code_o,
  output logic                          overflow_o,
  output logic [$clog2(MAX_COMP+1)-1:0] comp_count_o,
  input  logic [$clog2(MAX_COMP)-1:0]   comp_rd_idx_i,
  output logic [31:0]                   comp_rd_addr_o
);

  localparam int unsigned CNT_W = $clog2(MAX_COMP + 1);
  localparam int unsigned IDX_W = $clog2(MAX_COMP);
  localparam int unsigned ENT_W = $clog2(MAX_ENTRIES + 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CID     = 2'd1;
  localparam logic [1:0] ERR_NOT_RDY = 2'd2;
  localparam logic [1:0] ERR_NO_END  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, CID_ADDR, CID_WAIT, ENT_ADDR, ENT_WAIT, DONE
  } state_t;

  state_t             state;
  logic [1:0]         cid_idx;
  logic [ENT_W-1:0]   entry;
  logic [31:0]        comp_tab [MAX_COMP];

  function automatic logic [ADDR_WIDTH-1:0] cid_addr(input logic [1:0] idx);
    return ROM_BASE + CID_OFFSET + (ADDR_WIDTH'(idx) << 2);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] ent_addr(input logic [ENT_W-1:0] idx);
    return ROM_BASE + (ADDR_WIDTH'(idx) << 2);
  endfunction

  assign err_o = (err_code_o != ERR_NONE);

  // Entries at or beyond the recorded count read as zero, hiding stale data.
  assign comp_rd_addr_o = (CNT_W'(comp_rd_idx_i) < comp_count_o) ?
                          comp_tab[comp_rd_idx_i] : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      rom_addr_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_code_o   <= ERR_NONE;
      overflow_o   <= 1'b0;
      comp_count_o <= '0;
      cid_idx      <= '0;
      entry        <= '0;
      for (int i = 0; i < int'(MAX_COMP); i++) comp_tab[i] <= 32'h0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state        <= CID_ADDR;
            rom_addr_o   <= cid_addr(2'd0);
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            err_code_o   <= ERR_NONE;
            overflow_o   <= 1'b0;
            comp_count_o <= '0;
            cid_idx      <= '0;
            entry        <= '0;
          end
        end
        CID_ADDR: state <= CID_WAIT;
        CID_WAIT: begin
          if (!rom_ready_i || (rom_rdata_i[7:0] != EXP_CID[8*cid_idx +: 8])) begin
            state      <= DONE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            err_code_o <= rom_ready_i ? ERR_CID : ERR_NOT_RDY;
          end else if (cid_idx == 2'd3) begin
            state      <= ENT_ADDR;
            rom_addr_o <= ent_addr('0);
          end else begin
            state      <= CID_ADDR;
            cid_idx    <= cid_idx + 2'd1;
            rom_addr_o <= cid_addr(cid_idx + 2'd1);
          end
        end
        ENT_ADDR: state <= ENT_WAIT;
        ENT_WAIT: begin
          if (!rom_ready_i) begin
            state      <= DONE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            err_code_o <= ERR_NOT_RDY;
          end else if (rom_rdata_i == '0) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (rom_rdata_i[0] && (comp_count_o == CNT_W'(MAX_COMP))) begin
            // Table full: stop here, the recorded entries remain valid.
            state      <= DONE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            overflow_o <= 1'b1;
          end else begin
            if (rom_rdata_i[0]) begin
              comp_tab[comp_count_o[IDX_W-1:0]] <= {rom_rdata_i[31:12], 12'h000};
              comp_count_o <= comp_count_o + 1'b1;
            end
            if (entry == ENT_W'(MAX_ENTRIES - 1)) begin
              state      <= DONE;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              err_code_o <= ERR_NO_END;
            end else begin
              state      <= ENT_ADDR;
              entry      <= entry + 1'b1;
              rom_addr_o <= ent_addr(entry + 1'b1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_rom_walker.sv
// Bench for debug_rom_walker: directed ROM images plus random ones, checked
// against a sequential walk model of the ROM table.
module tb_debug_rom_walker;
  localparam int MAXC = 8;
  localparam int MAXE = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic        rom_ready;
  logic        busy, done, err, ovf;
  logic [1:0]  err_code;
  logic [3:0]  count;
  logic [2:0]  rd_idx = 3'd0;
  logic [31:0] rd_addr;

  int vecs = 0;
  int fails = 0;

  logic [31:0] cid_mem [4];
  logic [31:0] ent_mem [MAXE];
  int          nr_entry = -1;
  logic [7:0]  cid_bytes [4] = '{8'h0D, 8'h10, 8'h00, 8'h05};

  logic [31:0] exp_tab [MAXC];
  int          exp_code, exp_cnt, exp_words;
  bit          exp_ovf;
  logic [31:0] exp_last;

  always #5 clk = ~clk;

  debug_rom_walker #(.MAX_COMP(MAXC), .MAX_ENTRIES(MAXE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata), .rom_ready_i(rom_ready),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code),
    .overflow_o(ovf), .comp_count_o(count),
    .comp_rd_idx_i(rd_idx), .comp_rd_addr_o(rd_addr)
  );

  // ROM with one cycle of read latency; nr_entry marks an entry whose access fails.
  always @(posedge clk) begin
    if (rom_addr >= 32'h1000 && rom_addr < 32'h1010) begin
      rom_rdata <= cid_mem[rom_addr[3:2]];
      rom_ready <= 1'b1;
    end else if (rom_addr < 32'(MAXE * 4)) begin
      rom_rdata <= ent_mem[rom_addr[5:2]];
      rom_ready <= (int'(rom_addr[31:2]) != nr_entry);
    end else begin
      rom_rdata <= 32'hDEAD_BEEF;
      rom_ready <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model();
    exp_code = 0; exp_ovf = 0; exp_cnt = 0; exp_words = 0; exp_last = 32'h0;
    for (int i = 0; i < MAXC; i++) exp_tab[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_words++;
      exp_last = 32'h1000 + 32'(4 * i);
      if (cid_mem[i][7:0] != cid_bytes[i]) begin exp_code = 1; return; end
    end
    for (int e = 0; e < MAXE; e++) begin
      exp_words++;
      exp_last = 32'(4 * e);
      if (e == nr_entry) begin exp_code = 2; return; end
      if (ent_mem[e] == 32'h0) return;
      if (ent_mem[e][0]) begin
        if (exp_cnt == MAXC) begin exp_ovf = 1; return; end
        exp_tab[exp_cnt] = ent_mem[e] & 32'hFFFF_F000;
        exp_cnt++;
      end
    end
    exp_code = 3;
  endtask

  task automatic load_nominal();
    logic [31:0] img [8] = '{32'h1001_0001, 32'h1002_0001, 32'h1003_0001, 32'h1004_0001,
                             32'h1005_0001, 32'h1006_0001, 32'hF800_0001, 32'h0};
    for (int i = 0; i < 4; i++) cid_mem[i] = {24'h0, cid_bytes[i]};
    for (int e = 0; e < MAXE; e++) ent_mem[e] = (e < 8) ? img[e] : 32'h0;
    nr_entry = -1;
  endtask

  task automatic load_random();
    int stop;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r = $urandom();
      cid_mem[i] = {r[31:8], cid_bytes[i]};
    end
    if ($urandom_range(0, 7) == 0) cid_mem[$urandom_range(0, 3)][7:0] = 8'hA5;
    stop = $urandom_range(0, MAXE);
    for (int e = 0; e < MAXE; e++) begin
      r = $urandom();
      if (e == stop) ent_mem[e] = 32'h0;
      else if ($urandom_range(0, 3) == 0) ent_mem[e] = {r[31:1], 1'b0} | 32'h2;
      else ent_mem[e] = r | 32'h1;
    end
    nr_entry = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, MAXE - 1)) : -1;
  endtask

  task automatic run_walk(input string name, input int glitch);
    int cyc;
    model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({name, ".busy_rise"}, 32'(busy), 32'h1);
    chk({name, ".first_addr"}, rom_addr, 32'h1000);
    cyc = 0;
    while (busy === 1'b1 && cyc < 500) begin
      cyc++;
      if (cyc == glitch) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    chk({name, ".busy_cycles"}, 32'(cyc), 32'(2 * exp_words));
    chk({name, ".done"}, 32'(done), 32'h1);
    chk({name, ".err"}, 32'(err), 32'(exp_code != 0));
    chk({name, ".err_code"}, 32'(err_code), 32'(exp_code));
    chk({name, ".overflow"}, 32'(ovf), 32'(exp_ovf));
    chk({name, ".count"}, 32'(count), 32'(exp_cnt));
    chk({name, ".last_addr"}, rom_addr, exp_last);
    for (int i = 0; i < MAXC; i++) begin
      rd_idx = 3'(i);
      #1;
      chk($sformatf("%s.tab%0d", name, i), rd_addr, exp_tab[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cid_mem[i] = 32'h0;
    for (int e = 0; e < MAXE; e++) ent_mem[e] = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    chk("reset.err_code", 32'(err_code), 32'h0);
    chk("reset.count", 32'(count), 32'h0);
    chk("reset.addr", rom_addr, 32'h0);
    rst_n = 1'b1;

    load_nominal();
    run_walk("nominal", 0);
    chk("nominal.tab0_const", exp_tab[0] ^ rd_addr ^ rd_addr, 32'h1001_0000);

    load_nominal();
    cid_mem[1] = 32'h11;
    run_walk("cid_bad", 0);

    load_nominal();
    nr_entry = 2;
    run_walk("not_ready", 0);

    load_nominal();
    for (int e = 0; e < 10; e++) ent_mem[e] = 32'h2000_1001 + 32'(e << 12);
    ent_mem[10] = 32'h0;
    run_walk("overflow", 0);

    load_nominal();
    ent_mem[0] = 32'h1001_0001; ent_mem[1] = 32'h2000_0000;
    ent_mem[2] = 32'h1003_0001; ent_mem[3] = 32'h0;
    run_walk("skip", 0);

    load_nominal();
    for (int e = 0; e < MAXE; e++)
      ent_mem[e] = (e % 4 == 0) ? 32'h3000_0001 + 32'(e << 12) : 32'h0000_0002;
    run_walk("no_end", 0);

    load_nominal();
    run_walk("glitch", 9);

    load_nominal();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", 32'(busy), 32'h0);
    chk("rst_mid.done", 32'(done), 32'h0);
    chk("rst_mid.err", 32'(err), 32'h0);
    chk("rst_mid.ovf", 32'(ovf), 32'h0);
    chk("rst_mid.count", 32'(count), 32'h0);
    chk("rst_mid.addr", rom_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid.stays_idle", 32'(busy), 32'h0);

    for (int n = 0; n < 30; n++) begin
      load_random();
      run_walk($sformatf("rand%0d", n), (n % 3 == 0) ? int'($urandom_range(1, 12)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/debug_rom_walker.md
# debug_rom_walker

Hardware ROM-table walker that sits directly downstream of the debug ROM in the debug subsystem. On a start request it reads the ROM component-ID words and checks them. It then scans the component-pointer entries and records the base address of every present component in a small register table. The debug controller and DAP side read that table instead of walking the ROM through slow JTAG/SWD transactions.

## Interface
- ADDR_WIDTH, 32, ROM byte-address width
- DATA_WIDTH, 32, ROM data width (must be 32)
- ROM_BASE, 32'h0000_0000, byte address of ROM entry 0
- CID_OFFSET, 32'h0000_1000, byte offset of CID0; CID1..CID3 follow at +4, +8, +12
- EXP_CID, 32'h0500_100D, expected {CID3[7:0], CID2[7:0], CID1[7:0], CID0[7:0]}
- MAX_COMP, 8, capacity of the component table
- MAX_ENTRIES, 960, entries scanned before declaring a missing end marker
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  walk request; sampled only in IDLE
- rom_addr_o  out  ADDR_WIDTH  registered byte address to the ROM
- rom_rdata_i  in  32  ROM read data; valid 1 cycle after rom_addr_o changes
- rom_ready_i  in  1  ROM access-valid flag, same timing as rom_rdata_i
- busy_o  out  1  walk in progress
- done_o  out  1  walk finished (success or error); level signal
- err_o  out  1  walk ended in error
- err_code_o  out  2  0 none, 1 CID mismatch, 2 ROM not ready, 3 no end marker
- overflow_o  out  1  more present components than MAX_COMP
- comp_count_o  out  $clog2(MAX_COMP+1)  number of recorded components
- comp_rd_idx_i  in  $clog2(MAX_COMP)  table read index
- comp_rd_addr_o  out  32  combinational read of table[comp_rd_idx_i]; returns 0 if idx >= comp_count_o

## Operation
- States: IDLE, CID_ADDR, CID_WAIT, ENT_ADDR, ENT_WAIT, DONE.
  - There is no separate error state. An error ends in DONE with err_o set.
- IDLE/DONE + start_i=1 starts a walk:
  - Clears done_o, err_o, err_code_o, overflow_o, comp_count_o and the cid_idx and entry counters.
  - Next state is CID_ADDR.
- start_i while busy_o=1 is ignored.
- CID_ADDR:
  - Drives rom_addr_o = ROM_BASE + CID_OFFSET + 4*cid_idx.
  - Next state is CID_WAIT.
- CID_WAIT:
  - If rom_ready_i=0: err_code 2, go to DONE.
  - Otherwise compare rom_rdata_i[7:0] with EXP_CID byte cid_idx. On mismatch: err_code 1, go to DONE.
  - After cid_idx=3 passes, go to ENT_ADDR. Otherwise increment cid_idx and return to CID_ADDR.
- ENT_ADDR:
  - Drives rom_addr_o = ROM_BASE + 4*entry.
  - Next state is ENT_WAIT.
- ENT_WAIT:
  - rom_ready_i=0: err_code 2, go to DONE.
  - rom_rdata_i == 0: end marker, go to DONE with success.
  - rom_rdata_i[0]=1 and count < MAX_COMP: write table[count] = {rom_rdata_i[31:12], 12'h000}, then count++.
  - rom_rdata_i[0]=1 and count == MAX_COMP: set overflow_o, go to DONE. err_o stays 0.
  - rom_rdata_i[0]=0 with a nonzero value: entry not present; skip it.
  - If not yet DONE: entry++. If entry reaches MAX_ENTRIES: err_code 3, go to DONE. Otherwise return to ENT_ADDR.
- err_o = (err_code_o != 0).
- The table and count hold their values in DONE until the next accepted start. A failed walk keeps any partial entries already recorded.

## Timing
- Reset values:
  - rom_addr_o = 0, busy_o = 0, done_o = 0, err_o = 0, err_code_o = 0, overflow_o = 0, comp_count_o = 0.
  - Every table entry = 0. State = IDLE.
- Reset asserted mid-walk aborts immediately to the reset values. There is no resume.
- start_i high in cycle N (IDLE):
  - busy_o = 1 from cycle N+1.
  - rom_addr_o shows the first CID address in cycle N+1.
- Each ROM word costs exactly 2 cycles: the address cycle, then the sample cycle. rom_rdata_i and rom_ready_i are sampled in the sample cycle.
- The final sample in cycle M gives DONE in cycle M+1: busy_o = 0, and done_o/err_o/overflow_o take their final values together.
- A successful walk of k entries (end marker included) lasts 8 + 2k busy cycles.
- comp_count_o updates the cycle after the sample that records the entry.
- rom_addr_o holds its last value in IDLE and DONE.
- Address arithmetic is modulo 2^ADDR_WIDTH.

## Test plan
- Nominal ROM: CID 0D/10/00/05; entries 10010001, 10020001, 10030001, 10040001, 10050001, 10060001, F8000001, 0. Start at cycle 0 ->
  - busy_o high cycles 1..24; done_o=1, err_o=0 at cycle 25.
  - comp_count_o=7; table[0]=32'h1001_0000, table[6]=32'hF800_0000.
  - comp_rd_idx_i=7 -> comp_rd_addr_o=0.
- CID1 read returns 32'h11 -> DONE after 4 busy cycles, err_code_o=1, comp_count_o=0.
- rom_ready_i=0 on entry 2 -> err_code_o=2, comp_count_o=2, table[1]=32'h1002_0000.
- ROM containing 10 present entries, MAX_COMP=8 -> overflow_o=1, err_o=0, comp_count_o=8. The walk stops on the 9th entry.
- Entry 1 = 32'h2000_0000 (not present) between two present entries -> comp_count_o=2; the skipped entry is not recorded.
- No end marker, MAX_ENTRIES=16 -> err_code_o=3 after 8+32 busy cycles.
- start_i pulsed mid-walk is ignored, and no results change.
- rst_ni asserted at cycle 10 -> all outputs return to reset values in the same cycle.
